// File: rtl/vc_icache_pkg.sv
// Shared parameters, types and address-field helpers for the ifetch instruction cache.
package vc_icache_pkg;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned NUM_LINES  = 16;

   localparam int unsigned BYTE_W = 2;
   localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W  = $clog2(NUM_LINES);
   localparam int unsigned TAG_W  = ADDR_W - BYTE_W - OFF_W - IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MISS_REQ  = 2'd1,
      ST_MISS_FILL = 2'd2,
      ST_RESPOND   = 2'd3
   } icache_state_e;

   // Response payload: op1 is the even word of the pair, op2 the following word.
   typedef struct packed {
      logic [INSTR_W-1:0] op2;
      logic [INSTR_W-1:0] op1;
   } icache_pair_t;

   typedef logic [LINE_WORDS-1:0][INSTR_W-1:0] icache_line_t;

   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
      return addr[BYTE_W+OFF_W +: IDX_W];
   endfunction

   function automatic logic [OFF_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
      return addr[BYTE_W +: OFF_W];
   endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: word-granular synchronous fill writes, combinational read,
// and a one-cycle invalidate of every line.
module icache_array
   import vc_icache_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_inval,
   input  logic               i_word_we,
   input  logic               i_line_we,
   input  logic [IDX_W-1:0]   i_widx,
   input  logic [OFF_W-1:0]   i_wword,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic [TAG_W-1:0]   i_wtag,
   input  logic [IDX_W-1:0]   i_ridx,
   output logic               o_valid_c,
   output logic [TAG_W-1:0]   o_tag_c,
   output icache_line_t       o_line_c
);

   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   icache_line_t         r_data [NUM_LINES];

   // Only the valid bits are reset; stale tag/data are unreachable while invalid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (i_inval) begin
         r_valid <= '0;
      end else if (i_line_we) begin
         r_valid[i_widx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_word_we) begin
         r_data[i_widx][i_wword] <= i_wdata;
      end
      if (i_line_we) begin
         r_tag[i_widx] <= i_wtag;
      end
   end

   assign o_valid_c = r_valid[i_ridx];
   assign o_tag_c   = r_tag[i_ridx];
   assign o_line_c  = r_data[i_ridx];

endmodule

// File: rtl/icache_resp_unit.sv
// Direct-mapped read-only instruction cache answering ifetch with aligned opcode pairs,
// refilling whole lines from memory on a miss.
module icache_resp_unit
   import vc_icache_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 icache_req,
   input  logic [ADDR_W-1:0]    icache_req_addr,
   output logic                 icache_busy,
   output logic                 icache_rsp,
   output logic [2*INSTR_W-1:0] icache_rsp_data,
   input  logic                 flush,
   output logic                 mem_req,
   output logic [ADDR_W-1:0]    mem_req_addr,
   input  logic                 mem_req_rdy,
   input  logic                 mem_rsp,
   input  logic [INSTR_W-1:0]   mem_rsp_data
);

   icache_state_e      r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
   logic [OFF_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_flush_pend, w_flush_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_rsp, w_rsp_nxt;
   icache_pair_t       r_rsp_data, w_rsp_data_nxt;
   logic               r_mem_req, w_mem_req_nxt;
   logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;

   logic               w_inval, w_word_we, w_line_we;
   logic [ADDR_W-1:0]  w_laddr;
   logic [ADDR_W-1:0]  w_fill_addr;
   logic [OFF_W-1:0]   w_word, w_lo_sel, w_hi_sel;
   logic               w_valid, w_hit;
   logic [TAG_W-1:0]   w_tag;
   icache_line_t       w_line;

   // Lookups use the incoming address while idle, the captured miss address otherwise.
   assign w_laddr     = (r_state == ST_IDLE) ? icache_req_addr : r_addr;
   assign w_word      = get_word(w_laddr);
   assign w_lo_sel    = w_word & ~OFF_W'(1);
   assign w_hi_sel    = w_word | OFF_W'(1);
   assign w_fill_addr = {get_tag(w_laddr), get_idx(w_laddr), (BYTE_W+OFF_W)'(0)};
   assign w_hit       = w_valid & (w_tag == get_tag(w_laddr)) & ~flush;

   icache_array u_array (
      .clk       (clk),
      .reset     (reset),
      .i_inval   (w_inval),
      .i_word_we (w_word_we),
      .i_line_we (w_line_we),
      .i_widx    (get_idx(r_addr)),
      .i_wword   (r_cnt),
      .i_wdata   (mem_rsp_data),
      .i_wtag    (get_tag(r_addr)),
      .i_ridx    (get_idx(w_laddr)),
      .o_valid_c (w_valid),
      .o_tag_c   (w_tag),
      .o_line_c  (w_line)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_busy       <= 1'b0;
         r_rsp        <= 1'b0;
         r_rsp_data   <= '0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_flush_pend <= w_flush_nxt;
         r_busy       <= w_busy_nxt;
         r_rsp        <= w_rsp_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_mem_req    <= w_mem_req_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_cnt_nxt      = r_cnt;
      w_flush_nxt    = r_flush_pend;
      w_rsp_nxt      = 1'b0;
      w_rsp_data_nxt = r_rsp_data;
      w_mem_req_nxt  = 1'b0;
      w_mem_addr_nxt = r_mem_addr;
      w_inval        = 1'b0;
      w_word_we      = 1'b0;
      w_line_we      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_inval = flush;
            if (icache_req) begin
               if (w_hit) begin
                  w_rsp_nxt          = 1'b1;
                  w_rsp_data_nxt.op1 = w_line[w_lo_sel];
                  w_rsp_data_nxt.op2 = w_line[w_hi_sel];
               end else begin
                  w_state_nxt    = ST_MISS_REQ;
                  w_addr_nxt     = icache_req_addr;
                  w_mem_req_nxt  = 1'b1;
                  w_mem_addr_nxt = w_fill_addr;
               end
            end
         end
         ST_MISS_REQ: begin
            w_flush_nxt = r_flush_pend | flush;
            if (mem_req_rdy) begin
               w_state_nxt = ST_MISS_FILL;
               w_cnt_nxt   = '0;
            end else begin
               w_mem_req_nxt = 1'b1;
            end
         end
         ST_MISS_FILL: begin
            w_flush_nxt = r_flush_pend | flush;
            if (mem_rsp) begin
               w_word_we = 1'b1;
               w_cnt_nxt = r_cnt + OFF_W'(1);
               // The final beat is always the odd word of the last pair; forward it.
               if (r_cnt == OFF_W'(LINE_WORDS-1)) begin
                  w_line_we          = 1'b1;
                  w_state_nxt        = ST_RESPOND;
                  w_rsp_nxt          = 1'b1;
                  w_rsp_data_nxt.op1 = w_line[w_lo_sel];
                  w_rsp_data_nxt.op2 = (w_hi_sel == OFF_W'(LINE_WORDS-1)) ?
                                       mem_rsp_data : w_line[w_hi_sel];
               end
            end
         end
         ST_RESPOND: begin
            w_state_nxt = ST_IDLE;
            w_inval     = r_flush_pend | flush;
            w_flush_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != ST_IDLE) | w_flush_nxt;
   end

   assign icache_busy     = r_busy;
   assign icache_rsp      = r_rsp;
   assign icache_rsp_data = r_rsp_data;
   assign mem_req         = r_mem_req;
   assign mem_req_addr    = r_mem_addr;

endmodule

// File: tb/tb_icache_resp_unit.sv
// Directed bench for icache_resp_unit with a transaction-level cache model checked every cycle.
module tb_icache_resp_unit;

   localparam int unsigned LW = 4;
   localparam int unsigned NL = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        icache_req = 1'b0;
   logic [31:0] icache_req_addr = '0;
   logic        icache_busy;
   logic        icache_rsp;
   logic [63:0] icache_rsp_data;
   logic        flush = 1'b0;
   logic        mem_req;
   logic [31:0] mem_req_addr;
   logic        mem_req_rdy = 1'b0;
   logic        mem_rsp = 1'b0;
   logic [31:0] mem_rsp_data = '0;

   int n_checks = 0;
   int n_errors = 0;
   int gen = 0;

   always #5 clk = ~clk;

   icache_resp_unit dut (
      .clk             (clk),
      .reset           (reset),
      .icache_req      (icache_req),
      .icache_req_addr (icache_req_addr),
      .icache_busy     (icache_busy),
      .icache_rsp      (icache_rsp),
      .icache_rsp_data (icache_rsp_data),
      .flush           (flush),
      .mem_req         (mem_req),
      .mem_req_addr    (mem_req_addr),
      .mem_req_rdy     (mem_req_rdy),
      .mem_rsp         (mem_rsp),
      .mem_rsp_data    (mem_rsp_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference cache: contents and one outstanding miss, tracked as plain arrays.
   bit          m_valid [NL];
   logic [31:0] m_tag   [NL];
   logic [31:0] m_data  [NL][LW];
   logic [31:0] m_line  [LW];
   bit          m_out, m_granted, m_pend;
   int          m_beats;
   logic [31:0] m_addr;
   bit          exp_rsp = 0, exp_busy = 0, exp_mem_req = 0;
   logic [63:0] exp_data = '0;
   logic [31:0] exp_mem_addr = '0;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / (4*LW)) % NL);
   endfunction
   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return a / (4*LW*NL);
   endfunction
   function automatic int pair_of(input logic [31:0] a);
      return int'((a / 4) % LW) & ~1;
   endfunction

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         for (int i = 0; i < NL; i++) m_valid[i] = 0;
         m_out = 0; m_granted = 0; m_pend = 0; m_beats = 0;
         exp_rsp = 0; exp_busy = 0; exp_mem_req = 0; exp_data = '0; exp_mem_addr = '0;
      end else begin
         exp_rsp = 0;
         if (!m_out) begin
            if (flush) for (int i = 0; i < NL; i++) m_valid[i] = 0;
            if (icache_req) begin
               if (m_valid[idx_of(icache_req_addr)] &&
                   m_tag[idx_of(icache_req_addr)] == tag_of(icache_req_addr)) begin
                  exp_rsp  = 1;
                  exp_data = {m_data[idx_of(icache_req_addr)][pair_of(icache_req_addr)+1],
                              m_data[idx_of(icache_req_addr)][pair_of(icache_req_addr)]};
               end else begin
                  m_out = 1; m_granted = 0; m_beats = 0;
                  m_addr = icache_req_addr;
                  exp_mem_addr = icache_req_addr - (icache_req_addr % (4*LW));
               end
            end
         end else begin
            if (flush) m_pend = 1;
            if (!m_granted) begin
               if (mem_req_rdy) m_granted = 1;
            end else if (m_beats < LW) begin
               if (mem_rsp) begin
                  m_line[m_beats] = mem_rsp_data;
                  m_beats++;
                  if (m_beats == LW) begin
                     m_valid[idx_of(m_addr)] = 1;
                     m_tag[idx_of(m_addr)]   = tag_of(m_addr);
                     for (int k = 0; k < LW; k++) m_data[idx_of(m_addr)][k] = m_line[k];
                     exp_rsp  = 1;
                     exp_data = {m_line[pair_of(m_addr)+1], m_line[pair_of(m_addr)]};
                  end
               end
            end else begin
               m_out = 0;
               if (m_pend) for (int i = 0; i < NL; i++) m_valid[i] = 0;
               m_pend = 0;
            end
         end
         exp_busy    = m_out;
         exp_mem_req = m_out && !m_granted;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("rsp", {63'd0, icache_rsp}, {63'd0, exp_rsp});
      if (exp_rsp) chk("rsp_data", icache_rsp_data, exp_data);
      chk("busy", {63'd0, icache_busy}, {63'd0, exp_busy});
      chk("mem_req", {63'd0, mem_req}, {63'd0, exp_mem_req});
      chk("mem_req_addr", {32'd0, mem_req_addr}, {32'd0, exp_mem_addr});
   end

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a >> 2) + 32'h60 + 32'(gen) * 32'h1000;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic request(input logic [31:0] a, input bit fl);
      icache_req = 1'b1; icache_req_addr = a; flush = fl;
      step();
      icache_req = 1'b0; flush = 1'b0;
   endtask

   // Serves one line fill; returns in the cycle the response is presented.
   task automatic serve_fill(input int rdy_delay, input int flush_beat, input int gap_beat,
                             output logic [31:0] line);
      int waited = 0;
      while (!mem_req && waited < 20) begin step(); waited++; end
      chk("fill_start", {63'd0, mem_req}, 64'd1);
      line = mem_req_addr;
      for (int i = 0; i < rdy_delay; i++) begin
         icache_req = 1'b1; icache_req_addr = 32'h108;
         mem_rsp = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
         step();
      end
      icache_req = 1'b0; mem_rsp = 1'b0;
      mem_req_rdy = 1'b1;
      step();
      mem_req_rdy = 1'b0;
      for (int k = 0; k < LW; k++) begin
         mem_rsp = 1'b1; mem_rsp_data = memfn(line + 32'(4*k));
         flush = (k == flush_beat);
         step();
         mem_rsp = 1'b0; flush = 1'b0;
         if (k == gap_beat && k != LW-1) step();
      end
      gen++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] line;
      step(); step();
      chk("reset_busy", {63'd0, icache_busy}, 64'd0);
      chk("reset_rsp", {63'd0, icache_rsp}, 64'd0);
      chk("reset_rsp_data", icache_rsp_data, 64'd0);
      chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
      chk("reset_mem_addr", {32'd0, mem_req_addr}, 64'd0);
      reset = 1'b1;
      step();

      // Cold miss on 0x100
      request(32'h100, 1'b0);
      chk("cold_mem_req", {63'd0, mem_req}, 64'd1);
      chk("cold_mem_addr", {32'd0, mem_req_addr}, 64'h100);
      chk("cold_busy", {63'd0, icache_busy}, 64'd1);
      serve_fill(0, -1, -1, line);
      chk("cold_rsp", {63'd0, icache_rsp}, 64'd1);
      chk("cold_data", icache_rsp_data, 64'h0000_00A1_0000_00A0);
      step();
      chk("cold_unbusy", {63'd0, icache_busy}, 64'd0);

      // Hits, single and back-to-back
      request(32'h108, 1'b0);
      chk("hit_rsp", {63'd0, icache_rsp}, 64'd1);
      chk("hit_data", icache_rsp_data, 64'h0000_00A3_0000_00A2);
      chk("hit_no_mem_req", {63'd0, mem_req}, 64'd0);
      icache_req = 1'b1; icache_req_addr = 32'h100;
      step();
      chk("b2b_data0", icache_rsp_data, 64'h0000_00A1_0000_00A0);
      icache_req_addr = 32'h108;
      step();
      chk("b2b_data1", icache_rsp_data, 64'h0000_00A3_0000_00A2);
      icache_req = 1'b0;
      step();
      chk("b2b_rsp_end", {63'd0, icache_rsp}, 64'd0);

      // Memory backpressure, ignored requests and stray beats, gapped beats
      request(32'h240, 1'b0);
      serve_fill(5, -1, 1, line);
      chk("bp_line", {32'd0, line}, 64'h240);
      chk("bp_data", icache_rsp_data, 64'h0000_10F1_0000_10F0);
      step();

      // Conflict eviction at index 0
      request(32'h500, 1'b0);
      chk("evict_mem_addr", {32'd0, mem_req_addr}, 64'h500);
      serve_fill(0, -1, -1, line);
      chk("evict_data", icache_rsp_data, 64'h0000_21A1_0000_21A0);
      step();
      request(32'h100, 1'b0);
      chk("evict_remiss", {63'd0, mem_req}, 64'd1);
      serve_fill(0, -1, -1, line);
      chk("evict_refill_data", icache_rsp_data, 64'h0000_30A1_0000_30A0);
      step();

      // Flush in IDLE with a simultaneous request
      request(32'h100, 1'b1);
      chk("flush_idle_miss", {63'd0, mem_req}, 64'd1);
      serve_fill(0, -1, -1, line);
      step();
      request(32'h240, 1'b0);
      chk("flush_other_miss", {63'd0, mem_req}, 64'd1);
      serve_fill(0, -1, -1, line);
      step();

      // Flush during a fill
      request(32'h308, 1'b0);
      serve_fill(0, 1, -1, line);
      chk("flush_fill_rsp", {63'd0, icache_rsp}, 64'd1);
      chk("flush_fill_data", icache_rsp_data, 64'h0000_6123_0000_6122);
      step();
      chk("flush_fill_unbusy", {63'd0, icache_busy}, 64'd0);
      request(32'h308, 1'b0);
      chk("flush_fill_remiss", {63'd0, mem_req}, 64'd1);
      serve_fill(0, -1, -1, line);
      step();

      // Reset in the middle of a fill
      request(32'h100, 1'b0);
      chk("rst_fill_miss", {63'd0, mem_req}, 64'd1);
      mem_req_rdy = 1'b1;
      step();
      mem_req_rdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_rsp = 1'b1; mem_rsp_data = 32'h5A5A_0000 + 32'(k);
         step();
      end
      mem_rsp = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", {63'd0, icache_busy}, 64'd0);
      chk("rst_mid_mem_req", {63'd0, mem_req}, 64'd0);
      chk("rst_mid_mem_addr", {32'd0, mem_req_addr}, 64'd0);
      chk("rst_mid_rsp_data", icache_rsp_data, 64'd0);
      step(); step();
      reset = 1'b1;
      step();
      request(32'h100, 1'b0);
      chk("rst_refill_req", {63'd0, mem_req}, 64'd1);
      chk("rst_refill_addr", {32'd0, mem_req_addr}, 64'h100);
      serve_fill(0, -1, -1, line);
      chk("rst_refill_data", icache_rsp_data, 64'h0000_80A1_0000_80A0);
      step();
      request(32'h104, 1'b0);
      chk("rst_hit_rsp", {63'd0, icache_rsp}, 64'd1);
      step();
      request(32'h308, 1'b0);
      chk("rst_cleared_miss", {63'd0, mem_req}, 64'd1);
      serve_fill(0, -1, -1, line);
      step(); step(); step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
